// File: rtl/mig_ui_responder_if.sv
// MIG native user-interface signal bundle: initiator drives commands and write
// data, the responder returns read data and flow control.
interface mig_ui_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic         app_wdf_end;
  logic         app_wdf_wren;
  logic [15:0]  app_wdf_mask;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end;
  logic         app_rd_data_valid;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         init_calib_complete;
  logic         protocol_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    input  app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
           init_calib_complete, protocol_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    output app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
           init_calib_complete, protocol_err
  );
endinterface

// File: rtl/mig_ui_responder.sv
// Behavioural DDR3 MIG UI responder: RAM-backed, fixed read latency, bounded read queue.
// Define MIG_RESP_RANDOM_STALL_EN to replace periodic app_rdy stalls with LFSR stalls.
module mig_ui_responder #(
  parameter int DEPTH_WORDS  = 16384,
  parameter int RD_LATENCY   = 12,
  parameter int RD_QUEUE     = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mig_ui_responder_if.slave ui
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int OW = $clog2(RD_QUEUE + 1);
  localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic {ST_CALIB, ST_RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  calib_cnt_q, calib_cnt_d;
  logic           calib_done_q;
  logic           err_q;
  logic [OW-1:0]  outst_q;
  logic           stall, rdy, run;
  logic           cmd_ok, wr_cmd, wr_acc, rd_acc, ret, err_now;
  logic [AW-1:0]  word;
  logic           unused_addr_lsbs;

  logic [127:0]          ram [DEPTH_WORDS];
  logic [127:0]          rd_word_q;
  logic [127:0]          data_pipe_q [2:RD_LATENCY];
  logic [RD_LATENCY:1]   vld_pipe_q;

  assign run              = (state_q == ST_RUN);
  assign word             = AW'(ui.app_addr[26:3] % 24'(DEPTH_WORDS));
  assign unused_addr_lsbs = ^ui.app_addr[2:0];

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    case (state_q)
      ST_CALIB: begin
        if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) state_d = ST_RUN;
        else                                       calib_cnt_d = calib_cnt_q + 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CALIB;
    endcase
  end

`ifdef MIG_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)   lfsr_q <= 16'hACE1;
    else if (run) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[2:0] == 3'b000);
`else
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  logic [SW-1:0] stall_cnt_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)   stall_cnt_q <= '0;
    else if (run) stall_cnt_q <= (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
  end
  assign stall = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
`endif

  // The queue limit counts reads still in flight, including the one being returned now.
  assign rdy    = run && !stall && (outst_q < OW'(RD_QUEUE));
  assign cmd_ok = ui.app_en && rdy;
  assign wr_cmd = cmd_ok && (ui.app_cmd == 3'b000);
  assign rd_acc = cmd_ok && (ui.app_cmd == 3'b001);
  assign wr_acc = wr_cmd && ui.app_wdf_wren && ui.app_wdf_end;
  assign ret    = vld_pipe_q[RD_LATENCY];

  assign err_now = (wr_cmd && !ui.app_wdf_wren)
                 | (ui.app_wdf_wren && rdy && !wr_cmd)
                 | (ui.app_wdf_wren && !ui.app_wdf_end)
                 | (cmd_ok && (ui.app_cmd[2:1] != 2'b00))
                 | (ui.app_en && !run);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_CALIB;
      calib_cnt_q  <= '0;
      calib_done_q <= 1'b0;
      err_q        <= 1'b0;
      outst_q      <= '0;
      vld_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      calib_cnt_q  <= calib_cnt_d;
      calib_done_q <= (state_d == ST_RUN);
      err_q        <= err_q | err_now;
      vld_pipe_q   <= {vld_pipe_q[RD_LATENCY-1:1], rd_acc};
      case ({rd_acc, ret})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // RAM survives reset; read is synchronous so the array maps to block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_acc)
      for (int i = 0; i < 16; i++)
        if (!ui.app_wdf_mask[i]) ram[word][8*i +: 8] <= ui.app_wdf_data[8*i +: 8];
    if (rd_acc) rd_word_q <= ram[word];
  end

  always_ff @(posedge clk_in) begin
    data_pipe_q[2] <= rd_word_q;
    for (int k = 3; k <= RD_LATENCY; k++) data_pipe_q[k] <= data_pipe_q[k-1];
  end

  assign ui.app_rd_data         = ret ? data_pipe_q[RD_LATENCY] : '0;
  assign ui.app_rd_data_valid   = ret;
  assign ui.app_rd_data_end     = ret;
  assign ui.app_rdy             = rdy;
  assign ui.app_wdf_rdy         = rdy;
  assign ui.init_calib_complete = calib_done_q;
  assign ui.protocol_err        = err_q;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed + randomized bench for mig_ui_responder against a cycle-indexed
// reference: word map, list of pending reads with due cycles, calib/stall arithmetic.
module tb_mig_ui_responder;
  localparam int LAT = 12, QD = 8, CAL = 64, SP = 32, DEPTH = 16384;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  mig_ui_responder_if ui();

  mig_ui_responder #(
    .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .RD_QUEUE(QD),
    .CALIB_CYCLES(CAL), .STALL_PERIOD(SP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .ui(ui)
  );

  typedef struct {
    longint       due;
    logic [127:0] data;
  } rd_t;

  int           checks = 0;
  int           errors = 0;
  longint       cyc = 0;
  int           n = 0;
  int           rv_cnt = 0;
  bit           last_acc;
  logic         err_m = 1'b0;
  rd_t          q[$];
  logic [127:0] mem [int];

  function automatic int widx(logic [26:0] a);
    return int'(a >> 3) % DEPTH;
  endfunction

  function automatic bit m_rdy();
    return (n >= CAL) && (((n - CAL) % SP) != SP - 1) && (q.size() < QD);
  endfunction

  function automatic logic [127:0] mem_rd(int w);
    return mem.exists(w) ? mem[w] : '0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply model rules for the current inputs, clock, then compare outputs.
  task automatic tick();
    bit rdy;
    logic [127:0] w;
    int wi;
    last_acc = 1'b0;
    if (!rst_in) begin
      rdy = m_rdy();
      if (ui.app_en && n < CAL)                                   err_m = 1'b1;
      if (ui.app_en && rdy && ui.app_cmd > 3'd1)                  err_m = 1'b1;
      if (ui.app_wdf_wren && !ui.app_wdf_end)                     err_m = 1'b1;
      if (ui.app_en && rdy && ui.app_cmd == 3'd0 && !ui.app_wdf_wren) err_m = 1'b1;
      if (ui.app_wdf_wren && rdy && !(ui.app_en && ui.app_cmd == 3'd0)) err_m = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (ui.app_en && rdy && ui.app_cmd == 3'd1) begin
        q.push_back('{cyc + LAT, mem_rd(widx(ui.app_addr))});
        last_acc = 1'b1;
      end
      if (ui.app_en && rdy && ui.app_cmd == 3'd0 && ui.app_wdf_wren && ui.app_wdf_end) begin
        wi = widx(ui.app_addr);
        w  = mem_rd(wi);
        for (int i = 0; i < 16; i++)
          if (!ui.app_wdf_mask[i]) w[8*i +: 8] = ui.app_wdf_data[8*i +: 8];
        mem[wi] = w;
        last_acc = 1'b1;
      end
    end
    @(posedge clk_in);
    cyc++;
    if (rst_in) begin
      n = 0;
      q.delete();
      err_m = 1'b0;
    end else begin
      n++;
    end
    #1;
    if (ui.app_rd_data_valid === 1'b1) rv_cnt++;
    chk("app_rdy", ui.app_rdy, m_rdy());
    chk("app_wdf_rdy", ui.app_wdf_rdy, m_rdy());
    chk("init_calib_complete", ui.init_calib_complete, n >= CAL);
    chk("protocol_err", ui.protocol_err, err_m);
    begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rd_data_valid", ui.app_rd_data_valid, ev);
      chk("rd_data_end", ui.app_rd_data_end, ev);
      chk("rd_data", ui.app_rd_data, ev ? q[0].data : 128'h0);
    end
  endtask

  task automatic idle(int k);
    repeat (k) tick();
  endtask

  task automatic clr();
    ui.app_en = 1'b0; ui.app_cmd = 3'd0; ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
    ui.app_wdf_mask = '0;
  endtask

  task automatic wr(logic [26:0] a, logic [127:0] d, logic [15:0] m);
    int t = 0;
    ui.app_addr = a; ui.app_cmd = 3'd0; ui.app_en = 1'b1;
    ui.app_wdf_data = d; ui.app_wdf_mask = m; ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1;
    do begin tick(); t++; end while (!last_acc && t < 200);
    chk("wr_accept_timeout", last_acc, 1'b1);
    clr();
  endtask

  // Holds a read until accepted; returns the number of cycles the command was presented.
  task automatic rd(logic [26:0] a, output int t);
    t = 0;
    ui.app_addr = a; ui.app_cmd = 3'd1; ui.app_en = 1'b1;
    do begin tick(); t++; end while (!last_acc && t < 200);
    chk("rd_accept_timeout", last_acc, 1'b1);
    clr();
  endtask

  initial begin
    int t, base, nread;
    logic [26:0] a;
    clr();
    ui.app_addr = '0; ui.app_wdf_data = '0;

    // Reset, then calibration window (per-cycle checks cover timing of the rise).
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
    idle(CAL + 6);

    // Write word 5 then read it the very next cycle; also via a wrapped address.
    wr(27'd40, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 16'h0000);
    rd(27'd40, t);
    idle(LAT + 2);
    rd(27'(DEPTH * 8 + 40), t);
    idle(LAT + 2);

    // Byte-mask merge.
    wr(27'd24, {128{1'b1}}, 16'h0000);
    wr(27'd24, 128'h0, 16'h00FF);
    rd(27'd24, t);
    idle(LAT + 2);

    // Back-to-back read burst over prefilled random words.
    for (int i = 0; i < 16; i++) wr(27'((100 + i) * 8), rnd128(), 16'h0000);
    base = rv_cnt;
    nread = 0;
    for (int i = 0; i < 100; i++) begin
      ui.app_addr = 27'((100 + $urandom_range(0, 15)) * 8 + $urandom_range(0, 7));
      ui.app_cmd = 3'd1; ui.app_en = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!last_acc && t < 100);
      if (last_acc) nread++;
    end
    clr();
    idle(LAT + 2);
    chk("burst_accepted", nread, 100);
    chk("burst_returned", rv_cnt - base, 100);

    // Randomized mix of masked writes and reads.
    for (int i = 0; i < 16; i++) wr(27'((200 + i) * 8), rnd128(), 16'h0000);
    for (int i = 0; i < 40; i++) begin
      a = 27'((200 + $urandom_range(0, 15)) * 8);
      if ($urandom_range(0, 1) == 0) wr(a, rnd128(), 16'($urandom));
      else rd(a, t);
    end
    idle(LAT + 2);

    // Read presented during the stall cycle is held and accepted exactly once.
    t = 0;
    while (!(n >= CAL && ((n - CAL) % SP) == SP - 1) && t < 100) begin tick(); t++; end
    base = rv_cnt;
    rd(27'd40, t);
    chk("stall_hold_cycles", t, 2);
    idle(LAT + 2);
    chk("stall_single_return", rv_cnt - base, 1);

    // Stray write-data beat flags a sticky protocol error.
    t = 0;
    while (!m_rdy() && t < 100) begin tick(); t++; end
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1;
    tick();
    clr();
    idle(5);

    // Reset in the middle of a read burst: nothing returns, RAM contents persist.
    for (int i = 0; i < 5; i++) rd(27'd40, t);
    idle(3);
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    base = rv_cnt;
    idle(LAT + 3);
    chk("no_rd_after_reset", rv_cnt - base, 0);
    idle(CAL);
    rd(27'd40, t);
    idle(LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Synthesizable behavioural responder for the DDR3 MIG native user interface, for simulation and on-FPGA loopback.
- Takes the place of the MIG IP opposite a UI initiator such as the frame-buffer traffic generator.
- Accepts write/read commands, stores 128-bit words in internal RAM and returns read data after a fixed latency.
- Models calibration delay, app_rdy back-pressure and a bounded read queue, so initiator arbitration and address/TLAST logic can be exercised without DRAM.

Parameters:
- DEPTH_WORDS, 16384: number of 128-bit words stored; word index wraps modulo DEPTH_WORDS.
- RD_LATENCY, 12: cycles from read command acceptance to app_rd_data_valid (>=2).
- RD_QUEUE, 8: maximum outstanding (accepted, not yet returned) reads.
- CALIB_CYCLES, 64: cycles after reset before init_calib_complete rises.
- STALL_PERIOD, 32: app_rdy forced low one cycle in every STALL_PERIOD; 0 disables periodic stalls.

Ports:
- clk_in  in  1  UI clock.
- rst_in  in  1  synchronous active-high reset.
- app_addr  in  27  byte-group address; word index = app_addr[26:3], bits [2:0] ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_wdf_data  in  128  write data.
- app_wdf_end  in  1  last beat of write data; must accompany app_wdf_wren.
- app_wdf_wren  in  1  write data valid.
- app_wdf_mask  in  16  byte mask; 1 = byte not written.
- app_rd_data  out  128  read data.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- app_rd_data_valid  out  1  read data valid, no back-pressure.
- app_rdy  out  1  command accept.
- app_wdf_rdy  out  1  write data accept.
- init_calib_complete  out  1  calibration done.
- protocol_err  out  1  sticky violation flag.

Behaviour:
- One clock (clk_in). Reset (rst_in) is synchronous and active-high.
- Reset values: app_rdy=0, app_wdf_rdy=0, init_calib_complete=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, protocol_err=0.
- Reset clears read pipeline, outstanding counter, stall counter and FSM. RAM contents are not cleared.
- FSM CALIB:
  - counts CALIB_CYCLES cycles after reset release;
  - goes to RUN when count == CALIB_CYCLES-1;
  - init_calib_complete is registered high from the first RUN cycle.
- FSM RUN: terminal until reset.
- app_rdy = RUN && !stall && (outstanding < RD_QUEUE). app_wdf_rdy = app_rdy.
- Stall counter: free-runs 0..STALL_PERIOD-1 in RUN; stall = (count == STALL_PERIOD-1).
- Write accept: app_en && app_rdy && app_cmd==000 && app_wdf_wren && app_wdf_end in the same cycle.
  - Byte i of RAM[word] takes app_wdf_data[8i+7:8i] where app_wdf_mask[i]==0.
  - Writes are visible to a read accepted on the next cycle.
- Read accept: app_en && app_rdy && app_cmd==001.
  - RAM[word] is captured at acceptance and enters an RD_LATENCY-deep {valid,data} pipeline.
  - Output appears exactly RD_LATENCY cycles later, strictly in order, one word per cycle.
- Outstanding counter: +1 on read accept, -1 on app_rd_data_valid.
  - Simultaneous accept and return: counter unchanged.
  - When the counter reaches RD_QUEUE, app_rdy drops the next cycle.
- app_en while app_rdy=0: ignored, no error. The initiator must hold the command.
- protocol_err is set (sticky until reset) on any of:
  - write command accepted without app_wdf_wren;
  - app_wdf_wren && app_wdf_rdy without an accepted write command;
  - app_wdf_wren without app_wdf_end;
  - app_en with app_cmd not in {000,001} while app_rdy;
  - app_en during CALIB.
- Addresses >= DEPTH_WORDS*8 wrap modulo DEPTH_WORDS, no error.

Optional Feature:
- MIG_RESP_RANDOM_STALL_EN defined:
  - stall comes from a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset, advancing every RUN cycle;
  - stall = (lfsr[2:0] == 3'b000);
  - STALL_PERIOD is ignored.
- Not defined: periodic stall as described above.

Test Plan:
- Reset, idle -> init_calib_complete rises exactly 64 cycles after rst_in falls; app_rdy=0 before that; protocol_err=0.
- Write word 5 (app_addr=40) data 128'hDEAD...BEEF, mask 0, then read app_addr=40 next cycle -> app_rd_data_valid exactly 12 cycles after read accept, data 128'hDEAD...BEEF.
- Write 128'hFF..FF to word 3, then write 128'h0 with mask 16'h00FF, read back -> 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Issue reads back-to-back every cycle -> app_rdy low after 8 outstanding; resumes as data returns; returned order matches request order; no lost or duplicated words over 100 reads.
- Reads across STALL_PERIOD boundary -> app_rdy low exactly one cycle per 32 RUN cycles; a command held through the stall is accepted once.
- app_wdf_wren pulsed with no app_en -> protocol_err=1 next cycle and stays 1. Assert rst_in mid-read-burst -> no app_rd_data_valid after reset; RAM data persists.
